// File: rtl/camera_pkg.sv
// Shared types and constants for the camera pose controller: the Q16.16
// vector type, the reset basis, and the sine generator used to fill the
// quarter-wave ROM at elaboration time.
package camera_pkg;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
    } vec3_t;

    localparam int Q16_ONE = 65536;

    localparam vec3_t FORWARD_RST = '{x: 32'sd0,     y: 32'sd0,     z: -32'sd65536};
    localparam vec3_t UP_RST      = '{x: 32'sd0,     y: 32'sd65536, z: 32'sd0};
    localparam vec3_t RIGHT_RST   = '{x: 32'sd65536, y: 32'sd0,     z: 32'sd0};

    // pi scaled by 2^30
    localparam logic signed [63:0] PI_Q30 = 64'sd3373259426;

    // round(65536 * sin(idx/quarter * pi/2)) via a Horner-form Taylor series
    // in Q30 fixed point; only ever called with constant arguments.
    function automatic int sin_q16(input int unsigned idx, input int unsigned quarter);
        logic signed [63:0] x;
        logic signed [63:0] x2;
        logic signed [63:0] t;
        logic signed [63:0] s;
        x  = (64'(idx) * PI_Q30 + 64'(quarter)) / (64'(quarter) * 64'sd2);
        x2 = (x * x) >>> 30;
        t  = 64'sd1 <<< 30;
        for (int unsigned n = 6; n >= 1; n--) begin
            t = (64'sd1 <<< 30) - ((x2 * t) >>> 30) / $signed(64'((2 * n) * (2 * n + 1)));
        end
        s = (x * t) >>> 30;
        return int'((s + 64'sd8192) >>> 14);
    endfunction

endpackage

// File: rtl/camera_pose_ctrl_trig_lut.sv
// Registered sine lookup: quarter-wave ROM with quadrant folding. Output is
// signed Q1.16 (+/-65536 representable), one cycle after the angle.
module trig_lut
    import camera_pkg::*;
#(
    parameter int ANGLE_BITS = 9
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [ANGLE_BITS-1:0]    angle_in,
    output logic signed [17:0]       value_out
);

    localparam int QUARTER = 2 ** (ANGLE_BITS - 2);

    logic [16:0]             w_rom [QUARTER+1];
    logic [1:0]              w_quad;
    logic [ANGLE_BITS-3:0]   w_idx;
    logic [ANGLE_BITS-2:0]   w_addr;
    logic [16:0]             w_mag;

    for (genvar g = 0; g <= QUARTER; g++) begin : g_rom
        assign w_rom[g] = 17'(sin_q16(g, QUARTER));
    end

    assign w_quad = angle_in[ANGLE_BITS-1 -: 2];
    assign w_idx  = angle_in[ANGLE_BITS-3:0];

    // odd quadrants run the table backwards; the extra entry covers idx 0
    always_comb begin
        w_addr = {1'b0, w_idx};
        if (w_quad[0]) begin
            w_addr = (ANGLE_BITS-1)'(QUARTER) - {1'b0, w_idx};
        end
        w_mag = w_rom[w_addr];
    end

    // lower half-turn positive, upper half-turn negated
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            value_out <= '0;
        end else if (w_quad[1]) begin
            value_out <= -$signed({1'b0, w_mag});
        end else begin
            value_out <= $signed({1'b0, w_mag});
        end
    end

endmodule

// File: rtl/camera_pose_ctrl.sv
// Gyro-driven camera pose: integrates yaw/pitch rates and, on each rising
// edge of frame_done_in, produces a forward/up/right basis in Q16.16.
// Optional feature macro: CAMERA_POSE_DEADZONE_EN (small rates forced to 0).
module camera_pose_ctrl
    import camera_pkg::*;
#(
    parameter int ANGLE_BITS  = 9,
    parameter int RATE_SHIFT  = 8,
    parameter int PITCH_LIMIT = 112,
    parameter int DEADZONE    = 64
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    gyro_valid_in,
    input  logic signed [15:0]      gx_in,
    input  logic signed [15:0]      gy_in,
    input  logic signed [15:0]      gz_in,
    input  logic                    recenter_in,
    input  logic                    frame_done_in,
    output logic                    pose_valid_out,
    output logic signed [31:0]      forward_x_out,
    output logic signed [31:0]      forward_y_out,
    output logic signed [31:0]      forward_z_out,
    output logic signed [31:0]      up_x_out,
    output logic signed [31:0]      up_y_out,
    output logic signed [31:0]      up_z_out,
    output logic signed [31:0]      right_x_out,
    output logic signed [31:0]      right_y_out,
    output logic signed [31:0]      right_z_out,
    output logic [ANGLE_BITS-1:0]   yaw_out,
    output logic [ANGLE_BITS-1:0]   pitch_out
);

    localparam int ACC_W = ANGLE_BITS + RATE_SHIFT;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_MULT   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic signed [ACC_W:0]  PITCH_MAX = (ACC_W+1)'(PITCH_LIMIT * (2 ** RATE_SHIFT));
    localparam logic signed [ACC_W:0]  PITCH_MIN = -PITCH_MAX;
    localparam logic [ANGLE_BITS-1:0]  QTR       = ANGLE_BITS'(2 ** (ANGLE_BITS - 2));
    localparam logic signed [15:0]     DZ        = 16'(DEADZONE);

`ifdef CAMERA_POSE_DEADZONE_EN
    localparam logic DZ_EN = 1'b1;
`else
    localparam logic DZ_EN = 1'b0;
`endif

    logic [1:0]               r_state;
    logic [2:0]               r_cnt;
    logic                     r_fd_prev;
    logic [ACC_W-1:0]         r_yaw_acc;
    logic signed [ACC_W-1:0]  r_pitch_acc;
    logic [ANGLE_BITS-1:0]    r_yaw_snap;
    logic [ANGLE_BITS-1:0]    r_pitch_snap;
    logic signed [17:0]       r_sy;
    logic signed [17:0]       r_cy;
    logic signed [17:0]       r_sp;
    logic signed [17:0]       r_cp;
    logic signed [31:0]       r_prod [4];
    vec3_t                    r_fwd;
    vec3_t                    r_up;
    vec3_t                    r_right;
    logic                     r_pose_valid;

    logic signed [15:0]       w_gx;
    logic signed [15:0]       w_gy;
    logic signed [ACC_W:0]    w_pitch_sum;
    logic signed [ACC_W-1:0]  w_pitch_next;
    logic                     w_trigger;
    logic [ANGLE_BITS-1:0]    w_lut_angle;
    logic signed [17:0]       w_lut_value;
    logic signed [17:0]       w_mul_a;
    logic signed [17:0]       w_mul_b;
    logic signed [35:0]       w_prod;
    logic signed [31:0]       w_prod_q;
    logic                     w_unused_gz;

    assign w_unused_gz = ^gz_in;

    // rate conditioning; -32768 stays outside the dead band by signed compare
    always_comb begin
        w_gx = gx_in;
        w_gy = gy_in;
        if (DZ_EN && (gx_in > -DZ) && (gx_in < DZ)) begin
            w_gx = '0;
        end
        if (DZ_EN && (gy_in > -DZ) && (gy_in < DZ)) begin
            w_gy = '0;
        end
    end

    // pitch is summed one bit wider, then saturated
    always_comb begin
        w_pitch_sum  = {r_pitch_acc[ACC_W-1], r_pitch_acc} + (ACC_W+1)'(w_gx);
        w_pitch_next = r_pitch_acc;
        if (w_pitch_sum > PITCH_MAX) begin
            w_pitch_next = ACC_W'(PITCH_MAX);
        end else if (w_pitch_sum < PITCH_MIN) begin
            w_pitch_next = ACC_W'(PITCH_MIN);
        end else begin
            w_pitch_next = ACC_W'(w_pitch_sum);
        end
    end

    // angle integration runs regardless of FSM state; recenter wins
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_yaw_acc   <= '0;
            r_pitch_acc <= '0;
            r_fd_prev   <= 1'b0;
        end else begin
            r_fd_prev <= frame_done_in;
            if (recenter_in) begin
                r_yaw_acc   <= '0;
                r_pitch_acc <= '0;
            end else if (gyro_valid_in) begin
                r_yaw_acc   <= r_yaw_acc + ACC_W'(w_gy);
                r_pitch_acc <= w_pitch_next;
            end
        end
    end

    assign yaw_out   = r_yaw_acc[ACC_W-1 -: ANGLE_BITS];
    assign pitch_out = r_pitch_acc[ACC_W-1 -: ANGLE_BITS];

    assign w_trigger = (r_state == S_IDLE) && frame_done_in && !r_fd_prev;

    // lookup order: sin y, cos y, sin p, cos p (cos = sin shifted a quarter turn)
    always_comb begin
        case (r_cnt)
            3'd0:    w_lut_angle = r_yaw_snap;
            3'd1:    w_lut_angle = r_yaw_snap + QTR;
            3'd2:    w_lut_angle = r_pitch_snap;
            3'd3:    w_lut_angle = r_pitch_snap + QTR;
            default: w_lut_angle = '0;
        endcase
    end

    trig_lut #(
        .ANGLE_BITS (ANGLE_BITS)
    ) u_trig_lut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .angle_in  (w_lut_angle),
        .value_out (w_lut_value)
    );

    // single shared multiplier, operands selected by MULT step
    always_comb begin
        case (r_cnt[1:0])
            2'd0:    begin w_mul_a = r_cp; w_mul_b = r_sy; end
            2'd1:    begin w_mul_a = r_cp; w_mul_b = r_cy; end
            2'd2:    begin w_mul_a = r_sp; w_mul_b = r_sy; end
            default: begin w_mul_a = r_sp; w_mul_b = r_cy; end
        endcase
        w_prod   = w_mul_a * w_mul_b;
        w_prod_q = 32'(w_prod >>> 16);
    end

    // sequencing: snapshot, 4 lookups + drain, 4 multiplies, commit
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_yaw_snap   <= '0;
            r_pitch_snap <= '0;
            r_sy         <= '0;
            r_cy         <= '0;
            r_sp         <= '0;
            r_cp         <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_yaw_snap   <= yaw_out;
                        r_pitch_snap <= pitch_out;
                        r_cnt        <= '0;
                        r_state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    // LUT output trails the issued address by one cycle
                    case (r_cnt)
                        3'd1:    r_sy <= w_lut_value;
                        3'd2:    r_cy <= w_lut_value;
                        3'd3:    r_sp <= w_lut_value;
                        3'd4:    r_cp <= w_lut_value;
                        default: ;
                    endcase
                    if (r_cnt == 3'd4) begin
                        r_cnt   <= '0;
                        r_state <= S_MULT;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_MULT: begin
                    r_prod[r_cnt[1:0]] <= w_prod_q;
                    if (r_cnt == 3'd3) begin
                        r_cnt   <= '0;
                        r_state <= S_COMMIT;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // all nine outputs update together with the valid pulse
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_fwd        <= FORWARD_RST;
            r_up         <= UP_RST;
            r_right      <= RIGHT_RST;
            r_pose_valid <= 1'b0;
        end else begin
            r_pose_valid <= (r_state == S_COMMIT);
            if (r_state == S_COMMIT) begin
                r_fwd.x   <= r_prod[0];
                r_fwd.y   <= 32'(r_sp);
                r_fwd.z   <= -r_prod[1];
                r_up.x    <= -r_prod[2];
                r_up.y    <= 32'(r_cp);
                r_up.z    <= r_prod[3];
                r_right.x <= 32'(r_cy);
                r_right.y <= '0;
                r_right.z <= 32'(r_sy);
            end
        end
    end

    assign pose_valid_out = r_pose_valid;
    assign forward_x_out  = r_fwd.x;
    assign forward_y_out  = r_fwd.y;
    assign forward_z_out  = r_fwd.z;
    assign up_x_out       = r_up.x;
    assign up_y_out       = r_up.y;
    assign up_z_out       = r_up.z;
    assign right_x_out    = r_right.x;
    assign right_y_out    = r_right.y;
    assign right_z_out    = r_right.z;

endmodule

// File: tb/tb_camera_pose_ctrl.sv
// Bench for camera_pose_ctrl: directed scenarios plus random gyro/frame
// traffic, all outputs compared every cycle against a behavioural model.
module tb_camera_pose_ctrl;

    localparam real PI = 3.14159265358979323846;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               gyro_valid_in;
    logic signed [15:0] gx_in;
    logic signed [15:0] gy_in;
    logic signed [15:0] gz_in;
    logic               recenter_in;
    logic               frame_done_in;
    logic               pose_valid_out;
    logic signed [31:0] forward_x_out, forward_y_out, forward_z_out;
    logic signed [31:0] up_x_out, up_y_out, up_z_out;
    logic signed [31:0] right_x_out, right_y_out, right_z_out;
    logic [8:0]         yaw_out;
    logic [8:0]         pitch_out;

    camera_pose_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .gyro_valid_in  (gyro_valid_in),
        .gx_in          (gx_in),
        .gy_in          (gy_in),
        .gz_in          (gz_in),
        .recenter_in    (recenter_in),
        .frame_done_in  (frame_done_in),
        .pose_valid_out (pose_valid_out),
        .forward_x_out  (forward_x_out),
        .forward_y_out  (forward_y_out),
        .forward_z_out  (forward_z_out),
        .up_x_out       (up_x_out),
        .up_y_out       (up_y_out),
        .up_z_out       (up_z_out),
        .right_x_out    (right_x_out),
        .right_y_out    (right_y_out),
        .right_z_out    (right_z_out),
        .yaw_out        (yaw_out),
        .pitch_out      (pitch_out)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    task automatic check(input string name, input longint act, input longint exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_yaw, m_pitch;          // rate-unit accumulators
    int m_busy;                  // cycles until pending commit
    bit m_prev_fd;
    int m_snap_y, m_snap_p;      // angles (steps), pitch signed
    int e_f[3], e_u[3], e_r[3];
    bit m_pv;

    function automatic int q16(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction
    function automatic int tsin(input int a);
        return q16(65536.0 * $sin(2.0 * PI * a / 512.0));
    endfunction
    function automatic int tcos(input int a);
        return q16(65536.0 * $cos(2.0 * PI * a / 512.0));
    endfunction
    function automatic int qmul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return int'(p >>> 16);
    endfunction
    function automatic int cond_rate(input int r);
`ifdef CAMERA_POSE_DEADZONE_EN
        if (r > -64 && r < 64) return 0;
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_yaw = 0; m_pitch = 0; m_busy = 0; m_prev_fd = 0; m_pv = 0;
        m_snap_y = 0; m_snap_p = 0;
        e_f = '{0, 0, -65536};
        e_u = '{0, 65536, 0};
        e_r = '{65536, 0, 0};
    endtask

    task automatic model_commit();
        int sy, cy, sp, cp;
        sy = tsin(m_snap_y); cy = tcos(m_snap_y);
        sp = tsin(m_snap_p); cp = tcos(m_snap_p);
        e_f = '{qmul(cp, sy), sp, -qmul(cp, cy)};
        e_u = '{-qmul(sp, sy), cp, qmul(sp, cy)};
        e_r = '{cy, 0, sy};
    endtask

    initial model_reset();

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            model_reset();
        end else begin
            m_pv = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    model_commit();
                    m_pv = 1;
                end
            end else if (frame_done_in && !m_prev_fd) begin
                m_snap_y = m_yaw >> 8;
                m_snap_p = m_pitch >>> 8;
                m_busy   = 10;
            end
            if (recenter_in) begin
                m_yaw = 0; m_pitch = 0;
            end else if (gyro_valid_in) begin
                m_yaw   = (m_yaw + cond_rate(int'(gy_in))) & 32'h1FFFF;
                m_pitch = m_pitch + cond_rate(int'(gx_in));
                if (m_pitch > 28672)  m_pitch = 28672;
                if (m_pitch < -28672) m_pitch = -28672;
            end
            m_prev_fd = frame_done_in;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk_in) begin
        if (run_cmp && !rst_in) begin
            check("yaw_out",   yaw_out,   (m_yaw >> 8) & 511, 0);
            check("pitch_out", pitch_out, (m_pitch >>> 8) & 511, 0);
            check("pose_valid", pose_valid_out, m_pv, 0);
            check("forward_x", forward_x_out, e_f[0], 3);
            check("forward_y", forward_y_out, e_f[1], 3);
            check("forward_z", forward_z_out, e_f[2], 3);
            check("up_x",      up_x_out,      e_u[0], 3);
            check("up_y",      up_y_out,      e_u[1], 3);
            check("up_z",      up_z_out,      e_u[2], 3);
            check("right_x",   right_x_out,   e_r[0], 3);
            check("right_y",   right_y_out,   e_r[1], 3);
            check("right_z",   right_z_out,   e_r[2], 3);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic feed(input int n, input int gx, input int gy);
        gyro_valid_in = 1'b1;
        gx_in = 16'(gx);
        gy_in = 16'(gy);
        repeat (n) step();
        gyro_valid_in = 1'b0;
        gx_in = '0;
        gy_in = '0;
        step();
    endtask

    task automatic recenter();
        recenter_in = 1'b1;
        step();
        recenter_in = 1'b0;
        step();
    endtask

    task automatic trigger(input string name);
        int lat;
        lat = -1;
        frame_done_in = 1'b1;
        step();
        for (int k = 1; k <= 20; k++) begin
            step();
            if (pose_valid_out) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, lat, 10, 0);
        step();
        check({name, "_pulse_width"}, pose_valid_out, 0, 0);
        frame_done_in = 1'b0;
        step();
    endtask

    task automatic check_basis(input string name, input int fx, input int fy, input int fz,
                               input int ux, input int uy, input int uz,
                               input int rx, input int ry, input int rz);
        check({name, "_fx"}, forward_x_out, fx, 0);
        check({name, "_fy"}, forward_y_out, fy, 0);
        check({name, "_fz"}, forward_z_out, fz, 0);
        check({name, "_ux"}, up_x_out, ux, 0);
        check({name, "_uy"}, up_y_out, uy, 0);
        check({name, "_uz"}, up_z_out, uz, 0);
        check({name, "_rx"}, right_x_out, rx, 0);
        check({name, "_ry"}, right_y_out, ry, 0);
        check({name, "_rz"}, right_z_out, rz, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_in = 1'b1;
        gyro_valid_in = 1'b0;
        gx_in = '0; gy_in = '0; gz_in = '0;
        recenter_in = 1'b0;
        frame_done_in = 1'b0;

        // pin the model's trig/product helpers
        check("model_sin112", tsin(112), 64277, 0);
        check("model_cos0", tcos(0), 65536, 0);
        check("model_cos128", tcos(128), 0, 0);
        check("model_mul_one", qmul(65536, 65536), 65536, 0);

        repeat (3) step();
        check_basis("reset", 0, 0, -65536, 0, 65536, 0, 65536, 0, 0);
        check("reset_pose_valid", pose_valid_out, 0, 0);
        rst_in = 1'b0;
        run_cmp = 1'b1;
        step();
        check("reset_yaw", yaw_out, 0, 0);
        check("reset_pitch", pitch_out, 0, 0);

        // zero-angle pose equals the reset basis
        trigger("zero");
        check_basis("zero", 0, 0, -65536, 0, 65536, 0, 65536, 0, 0);

        // quarter turn of yaw
        feed(128, 0, 256);
        check("yaw_quarter", yaw_out, 128, 0);
        trigger("yaw90");
        check_basis("yaw90", 65536, 0, 0, 0, 65536, 0, 0, 0, 65536);

        // reset mid-computation: back to reset values immediately, no commit
        frame_done_in = 1'b1;
        repeat (6) step();
        rst_in = 1'b1;
        #1;
        check_basis("midrst", 0, 0, -65536, 0, 65536, 0, 65536, 0, 0);
        check("midrst_pose_valid", pose_valid_out, 0, 0);
        check("midrst_yaw", yaw_out, 0, 0);
        step();
        frame_done_in = 1'b0;
        rst_in = 1'b0;
        repeat (15) step();

        // pitch saturation
        recenter();
        feed(10, 32767, 0);
        check("pitch_clamp", pitch_out, 112, 0);
        trigger("pitch");
        check("pitch_forward_y", forward_y_out, 64277, 1);

        // yaw wrap, then recenter overriding a same-cycle sample
        recenter();
        feed(600, 0, 256);
        check("yaw_wrap", yaw_out, 88, 0);
        recenter_in = 1'b1;
        gyro_valid_in = 1'b1;
        gx_in = 16'sd1000;
        gy_in = 16'sd256;
        step();
        recenter_in = 1'b0;
        gyro_valid_in = 1'b0;
        gx_in = '0;
        gy_in = '0;
        step();
        check("recenter_yaw", yaw_out, 0, 0);
        check("recenter_pitch", pitch_out, 0, 0);

        // small rates: dead band behaviour
        feed(1000, 0, 32);
`ifdef CAMERA_POSE_DEADZONE_EN
        check("small_rate_yaw", yaw_out, 0, 0);
`else
        check("small_rate_yaw", yaw_out, 125, 0);
`endif

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            int v;
            gyro_valid_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) begin
                v = int'($urandom_range(0, 200)) - 100;
                gx_in = 16'(v);
            end else begin
                gx_in = 16'($urandom);
            end
            if ($urandom_range(0, 1) == 0) begin
                v = int'($urandom_range(0, 200)) - 100;
                gy_in = 16'(v);
            end else begin
                gy_in = 16'($urandom);
            end
            gz_in = 16'($urandom);
            recenter_in = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 5) == 0) frame_done_in = ~frame_done_in;
            step();
        end
        gyro_valid_in = 1'b0;
        recenter_in = 1'b0;
        frame_done_in = 1'b0;
        repeat (15) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
